fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  Fetch-stage PC sequencer that sits directly upstream of instr_mem.
//  Drives the instr_mem byte address and tracks the one-cycle synchronous read latency,
//  so that each instruction word leaves the stage tagged with its PC and a valid bit.
//  Supports stall (replay, zero bubble), taken-branch redirect, and an out-of-range fetch fault.
// PARAMETERS
//  RESET_PC   0     byte address of the first fetch after reset (word aligned)
//  IMEM_SIZE  1024  instruction memory depth in words; must equal instr_mem SIZE
// PORTS
//  clk            in   1           rising-edge clock
//  reset          in   1           synchronous, active-high
//  stall          in   1           downstream cannot accept; hold current instruction
//  branch_taken   in   1           redirect fetch to branch_target
//  branch_target  in   `WORD       redirect byte address; bits[1:0] ignored
//  imem_addr      out  `WORD       byte address to instr_mem.address (combinational)
//  imem_instr     in   `INSTR_LEN  instr_mem.instruction (registered in instr_mem)
//  instr          out  `INSTR_LEN  = imem_instr (pass-through)
//  pc             out  `WORD       byte address of instr
//  pc_plus4       out  `WORD       pc + 4, modulo 2^`WORD
//  instr_valid    out  1           instr/pc meaningful and consumable this cycle
//  fetch_fault    out  1           sticky: sequential fetch ran past memory end
// BEHAVIOUR
//  Registers: fetch_pc (next address to read), out_pc (drives pc), valid_q, state.
//  FSM states: BOOT, RUN, FAULT.
//   - reset=1: state<=BOOT, fetch_pc<=RESET_PC, out_pc<=RESET_PC, valid_q<=0, fetch_fault<=0.
//     Reset overrides every other input, including mid-stall and mid-branch.
//   - BOOT: imem_addr=fetch_pc, stall ignored. At the edge: out_pc<=fetch_pc,
//     fetch_pc<=fetch_pc+4, valid_q<=1, state<=RUN. First instr is valid 1 cycle after reset falls.
//   - RUN, select imem_addr by priority:
//       1. branch_taken: imem_addr={branch_target[W-1:2],2'b00}.
//       2. stall: imem_addr=out_pc (memory re-reads the same word, so instr stays stable).
//       3. otherwise: imem_addr=fetch_pc.
//     Update at the edge if imem_addr < 4*IMEM_SIZE:
//       - branch: out_pc<=target, fetch_pc<=target+4.
//       - stall: no change.
//       - otherwise: out_pc<=fetch_pc, fetch_pc<=fetch_pc+4.
//     If imem_addr >= 4*IMEM_SIZE: state<=FAULT, valid_q<=0, fetch_fault<=1, PCs held.
//   - FAULT: imem_addr=out_pc, stall ignored.
//     branch_taken with an in-range target performs the redirect as in RUN:
//     state<=RUN, valid_q<=1, fetch_fault<=0. An out-of-range target keeps the stage in FAULT.
//  instr_valid = valid_q & ~branch_taken. The instruction shown in a redirect cycle is
//   wrong-path and must not be consumed; downstream flushes older wrong-path work.
//  Latency: address to instruction is 1 cycle. Sequential throughput is 1 instr/cycle.
//   Stall release has no bubble. Redirect costs exactly the squashed slot.
//  pc_plus4 = out_pc+4. Wraps at 2^`WORD; the range check catches it before use.
//  Stall has no effect in BOOT or FAULT. branch_taken with stall in the same cycle: branch wins.
//  Reset values: instr_valid=0, pc=RESET_PC, pc_plus4=RESET_PC+4, fetch_fault=0,
//   imem_addr=RESET_PC.
// TESTING
//  1. imem words 0..3 = A,B,C,D; reset 3 cycles, then release -> cycles +1,+2,+3 give
//     (A,pc=0), (B,4), (C,8) with instr_valid=1; imem_addr = 4, 8, 12.
//  2. stall=1 for 2 cycles while (B,4) is shown -> (B,4) held 3 cycles in total,
//     then (C,8) in the next cycle; no gap in instr_valid.
//  3. branch_taken with target 0x43 while (C,8) is shown -> instr_valid=0 that cycle;
//     next cycle instr=imem[16], pc=0x40, pc_plus4=0x44; then pc=0x44.
//  4. branch_taken=1 and stall=1 in the same cycle, target 0x20 -> next cycle pc=0x20
//     with instr_valid=1 (branch wins).
//  5. IMEM_SIZE=8, run sequentially to pc=0x1C -> next edge fetch_fault=1, instr_valid=0,
//     pc held at 0x1C.
//     Then branch to 0x50 -> still FAULT. Then branch to 0x0 -> next cycle pc=0,
//     instr_valid=1, fetch_fault=0.
//  6. Assert reset during a stall at pc=0x10 -> next cycle instr_valid=0, pc=RESET_PC;
//     valid (A,0) one cycle after reset is released.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch-stage PC sequencer in front of a synchronous instruction memory.
// It drives the byte address into the memory and tracks the one-cycle read latency,
// so each instruction word leaves the stage tagged with its PC and a valid bit.
// It also handles stall replay, taken-branch redirect and out-of-range fetch faults.
//
// Ports:
//   clk, reset     rising-edge clock; synchronous active-high reset
//   stall          downstream cannot accept; hold the current instruction
//   branch_taken   redirect fetch to branch_target (bits [1:0] ignored)
//   branch_target  redirect byte address
//   imem_addr      byte address to instr_mem (combinational)
//   imem_instr     instruction word from instr_mem (registered inside the memory)
//   instr          pass-through of imem_instr
//   pc, pc_plus4   byte address of instr, and that address + 4
//   instr_valid    instr/pc may be consumed this cycle
//   fetch_fault    sticky flag: a fetch ran past the end of memory
module fetch_pc_unit #(
  parameter int          WORD_W    = 32,
  parameter int          INSTR_W   = 32,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          IMEM_SIZE = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [WORD_W-1:0]  branch_target,
  output logic [WORD_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [INSTR_W-1:0] instr,
  output logic [WORD_W-1:0]  pc,
  output logic [WORD_W-1:0]  pc_plus4,
  output logic               instr_valid,
  output logic               fetch_fault
);

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

  // One extra bit so 4*IMEM_SIZE never aliases to zero for a full-width memory.
  localparam logic [WORD_W:0]   LIMIT = (WORD_W+1)'(4 * IMEM_SIZE);
  localparam logic [WORD_W-1:0] PC0   = WORD_W'(RESET_PC);
  localparam logic [WORD_W-1:0] FOUR  = WORD_W'(4);

  state_t            state, state_n;
  logic [WORD_W-1:0] fetch_pc, fetch_pc_n;
  logic [WORD_W-1:0] out_pc, out_pc_n;
  logic              valid_q, valid_n;
  logic              fault_q, fault_n;
  logic [WORD_W-1:0] tgt;
  logic              in_range;

  assign tgt      = {branch_target[WORD_W-1:2], 2'b00};
  assign in_range = {1'b0, imem_addr} < LIMIT;

  // Address select. Stall re-reads out_pc so the registered memory output
  // keeps presenting the same word while the stage is held.
  always_comb begin
    imem_addr = fetch_pc;
    case (state)
      BOOT:    imem_addr = fetch_pc;
      RUN: begin
        if (branch_taken)  imem_addr = tgt;
        else if (stall)    imem_addr = out_pc;
        else               imem_addr = fetch_pc;
      end
      FAULT:   imem_addr = branch_taken ? tgt : out_pc;
      default: imem_addr = fetch_pc;
    endcase
  end

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    out_pc_n   = out_pc;
    valid_n    = valid_q;
    fault_n    = fault_q;
    case (state)
      BOOT: begin
        out_pc_n   = fetch_pc;
        fetch_pc_n = fetch_pc + FOUR;
        valid_n    = 1'b1;
        state_n    = RUN;
      end
      RUN: begin
        if (!in_range) begin
          // PCs hold so pc reports the last good instruction.
          state_n = FAULT;
          valid_n = 1'b0;
          fault_n = 1'b1;
        end else if (branch_taken) begin
          out_pc_n   = tgt;
          fetch_pc_n = tgt + FOUR;
        end else if (!stall) begin
          out_pc_n   = fetch_pc;
          fetch_pc_n = fetch_pc + FOUR;
        end
      end
      FAULT: begin
        if (branch_taken && in_range) begin
          out_pc_n   = tgt;
          fetch_pc_n = tgt + FOUR;
          state_n    = RUN;
          valid_n    = 1'b1;
          fault_n    = 1'b0;
        end
      end
      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BOOT;
      fetch_pc <= PC0;
      out_pc   <= PC0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      out_pc   <= out_pc_n;
      valid_q  <= valid_n;
      fault_q  <= fault_n;
    end
  end

  assign instr       = imem_instr;
  assign pc          = out_pc;
  assign pc_plus4    = out_pc + FOUR;
  // Word shown during a redirect is wrong-path.
  assign instr_valid = valid_q & ~branch_taken;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken;
  logic [31:0] branch_target;

  logic [31:0] addr_b, instr_in_b, instr_b, pc_b, pc4_b;
  logic        vld_b, flt_b;
  logic [31:0] addr_s, instr_in_s, instr_s, pc_s, pc4_s;
  logic        vld_s, flt_s;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(.RESET_PC(32'h0), .IMEM_SIZE(1024)) u_big (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(addr_b), .imem_instr(instr_in_b),
    .instr(instr_b), .pc(pc_b), .pc_plus4(pc4_b), .instr_valid(vld_b),
    .fetch_fault(flt_b));

  fetch_pc_unit #(.RESET_PC(32'h0), .IMEM_SIZE(8)) u_small (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(addr_s), .imem_instr(instr_in_s),
    .instr(instr_s), .pc(pc_s), .pc_plus4(pc4_s), .instr_valid(vld_s),
    .fetch_fault(flt_s));

  // Synchronous-read memory models: word n holds 0xC0DE0000 + n.
  function automatic logic [31:0] mw(input int n);
    return 32'hC0DE_0000 + 32'(n);
  endfunction

  always @(posedge clk) begin
    instr_in_b <= 32'hC0DE_0000 + {18'h0, addr_b[15:2]};
    instr_in_s <= 32'hC0DE_0000 + {18'h0, addr_s[15:2]};
  end

  // Advance one cycle; inputs are then driven for the new cycle, outputs sampled at negedge.
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    cyc(); cyc();
    reset = 1'b0;  // this cycle is BOOT
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
    cyc(); cyc();
    stall = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
    ncmp++;
    if ({vld_b, pc_b, pc4_b, flt_b, addr_b} !== {1'b0, 32'h0, 32'h4, 1'b0, 32'h0}) begin
      nerr++;
      $display("FAIL reset_state: got vld=%0b pc=%h pc4=%h flt=%0b addr=%h, want 0/0/4/0/0",
               vld_b, pc_b, pc4_b, flt_b, addr_b);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    @(negedge clk);
    ncmp++;
    if ({vld_b, addr_b} !== {1'b0, 32'h0}) begin
      nerr++; $display("FAIL boot_cycle: got vld=%0b addr=%h, want 0/0", vld_b, addr_b);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      ncmp++;
      if ({vld_b, instr_b, pc_b, addr_b} !== {1'b1, mw(k), 32'(4*k), 32'(4*k+4)}) begin
        nerr++;
        $display("FAIL seq_%0d: got vld=%0b instr=%h pc=%h addr=%h, want 1/%h/%h/%h", k,
                 vld_b, instr_b, pc_b, addr_b, mw(k), 32'(4*k), 32'(4*k+4));
      end
    end
  endtask

  task automatic test_stall_and_branch();
    do_reset();
    cyc();               // (A,0)
    cyc(); stall = 1'b1; // (B,4) shown, stalled
    @(negedge clk);
    ncmp++;
    if ({vld_b, instr_b, pc_b, addr_b} !== {1'b1, mw(1), 32'h4, 32'h4}) begin
      nerr++; $display("FAIL stall_0: got vld=%0b instr=%h pc=%h addr=%h, want 1/%h/4/4",
                       vld_b, instr_b, pc_b, addr_b, mw(1));
    end
    for (int k = 1; k < 3; k++) begin
      cyc(); stall = (k == 1);
      @(negedge clk);
      ncmp++;
      if ({vld_b, instr_b, pc_b} !== {1'b1, mw(1), 32'h4}) begin
        nerr++; $display("FAIL stall_%0d: got vld=%0b instr=%h pc=%h, want 1/%h/4",
                         k, vld_b, instr_b, pc_b, mw(1));
      end
    end
    cyc();               // (C,8); redirect to 0x43
    branch_taken = 1'b1; branch_target = 32'h43;
    @(negedge clk);
    ncmp++;
    if ({vld_b, instr_b, pc_b, addr_b} !== {1'b0, mw(2), 32'h8, 32'h40}) begin
      nerr++; $display("FAIL branch_slot: got vld=%0b instr=%h pc=%h addr=%h, want 0/%h/8/40",
                       vld_b, instr_b, pc_b, addr_b, mw(2));
    end
    cyc(); branch_taken = 1'b0;
    @(negedge clk);
    ncmp++;
    if ({vld_b, instr_b, pc_b, pc4_b} !== {1'b1, mw(16), 32'h40, 32'h44}) begin
      nerr++; $display("FAIL branch_land: got vld=%0b instr=%h pc=%h pc4=%h, want 1/%h/40/44",
                       vld_b, instr_b, pc_b, pc4_b, mw(16));
    end
    cyc();
    @(negedge clk);
    ncmp++;
    if ({vld_b, instr_b, pc_b} !== {1'b1, mw(17), 32'h44}) begin
      nerr++; $display("FAIL branch_next: got vld=%0b instr=%h pc=%h, want 1/%h/44",
                       vld_b, instr_b, pc_b, mw(17));
    end
    // Branch and stall together: branch wins.
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h20;
    cyc(); stall = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
    ncmp++;
    if ({vld_b, instr_b, pc_b, flt_b} !== {1'b1, mw(8), 32'h20, 1'b0}) begin
      nerr++; $display("FAIL branch_vs_stall: got vld=%0b instr=%h pc=%h flt=%0b, want 1/%h/20/0",
                       vld_b, instr_b, pc_b, flt_b, mw(8));
    end
  endtask

  task automatic test_fault();
    do_reset();
    for (int k = 0; k < 8; k++) cyc();  // now showing pc=0x1C
    @(negedge clk);
    ncmp++;
    if ({vld_s, pc_s, flt_s, addr_s} !== {1'b1, 32'h1C, 1'b0, 32'h20}) begin
      nerr++; $display("FAIL last_word: got vld=%0b pc=%h flt=%0b addr=%h, want 1/1c/0/20",
                       vld_s, pc_s, flt_s, addr_s);
    end
    cyc();
    @(negedge clk);
    ncmp++;
    if ({vld_s, pc_s, flt_s, addr_s} !== {1'b0, 32'h1C, 1'b1, 32'h1C}) begin
      nerr++; $display("FAIL fault_entry: got vld=%0b pc=%h flt=%0b addr=%h, want 0/1c/1/1c",
                       vld_s, pc_s, flt_s, addr_s);
    end
    branch_taken = 1'b1; branch_target = 32'h50;
    cyc(); branch_taken = 1'b0;
    @(negedge clk);
    ncmp++;
    if ({vld_s, pc_s, flt_s} !== {1'b0, 32'h1C, 1'b1}) begin
      nerr++; $display("FAIL fault_bad_target: got vld=%0b pc=%h flt=%0b, want 0/1c/1",
                       vld_s, pc_s, flt_s);
    end
    stall = 1'b1;  // ignored in FAULT
    cyc();
    @(negedge clk);
    ncmp++;
    if ({vld_s, pc_s, flt_s} !== {1'b0, 32'h1C, 1'b1}) begin
      nerr++; $display("FAIL fault_sticky: got vld=%0b pc=%h flt=%0b, want 0/1c/1",
                       vld_s, pc_s, flt_s);
    end
    stall = 1'b0; branch_taken = 1'b1; branch_target = 32'h0;
    cyc(); branch_taken = 1'b0;
    @(negedge clk);
    ncmp++;
    if ({vld_s, instr_s, pc_s, flt_s} !== {1'b1, mw(0), 32'h0, 1'b0}) begin
      nerr++; $display("FAIL fault_recover: got vld=%0b instr=%h pc=%h flt=%0b, want 1/%h/0/0",
                       vld_s, instr_s, pc_s, flt_s, mw(0));
    end
    cyc();
    @(negedge clk);
    ncmp++;
    if ({vld_s, instr_s, pc_s} !== {1'b1, mw(1), 32'h4}) begin
      nerr++; $display("FAIL fault_resume: got vld=%0b instr=%h pc=%h, want 1/%h/4",
                       vld_s, instr_s, pc_s, mw(1));
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    for (int k = 0; k < 5; k++) cyc();  // showing pc=0x10
    stall = 1'b1;
    @(negedge clk);
    ncmp++;
    if ({vld_b, pc_b} !== {1'b1, 32'h10}) begin
      nerr++; $display("FAIL pre_reset: got vld=%0b pc=%h, want 1/10", vld_b, pc_b);
    end
    reset = 1'b1;
    cyc();
    @(negedge clk);
    ncmp++;
    if ({vld_b, pc_b, pc4_b, addr_b} !== {1'b0, 32'h0, 32'h4, 32'h0}) begin
      nerr++; $display("FAIL reset_mid_stall: got vld=%0b pc=%h pc4=%h addr=%h, want 0/0/4/0",
                       vld_b, pc_b, pc4_b, addr_b);
    end
    reset = 1'b0; stall = 1'b0;
    cyc();
    @(negedge clk);
    ncmp++;
    if ({vld_b, instr_b, pc_b} !== {1'b1, mw(0), 32'h0}) begin
      nerr++; $display("FAIL restart: got vld=%0b instr=%h pc=%h, want 1/%h/0",
                       vld_b, instr_b, pc_b, mw(0));
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    test_reset();
    test_sequential();
    test_stall_and_branch();
    test_fault();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
